unified_mem_arbiter: RTL and testbench
======================================

// Module: unified_mem_arbiter
// PURPOSE
//  Shares one single-port synchronous RAM (1-cycle read latency) between the CPU instruction-fetch port and data port.
//  Grants one access per cycle and routes the response back to its owner one cycle later.
//  Converts byte/half/word MemOp accesses into word address + byte enables; aligns and extends load data.
//  Detects misaligned data accesses. Sits between the cpu core and the unified instruction/data RAM.
// PARAMETERS
//  ADDR_W        32  byte-address width of both requesters
//  MAX_DATA_RUN  4   max consecutive data grants while fetch is waiting; next grant is forced to fetch
// PORTS
//  clk        in   1         clock, rising-edge
//  rst        in   1         reset, asynchronous, active-high
//  if_req     in   1         fetch request; if_addr is held stable until if_gnt
//  if_addr    in   ADDR_W    fetch byte address; bits [1:0] ignored
//  if_gnt     out  1         fetch accepted this cycle (combinational)
//  if_rvalid  out  1         fetch data valid (one cycle after if_gnt)
//  if_rdata   out  32        fetched word
//  d_req      in   1         data request; all d_* inputs are held stable until d_gnt or d_err
//  d_we       in   1         1 = store, 0 = load
//  d_memop    in   3         000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu; any other code is treated as lw
//  d_addr     in   ADDR_W    data byte address
//  d_wdata    in   32        store data, LSB-justified
//  d_gnt      out  1         data accepted this cycle (combinational)
//  d_rvalid   out  1         load data valid / store complete (one cycle after d_gnt)
//  d_rdata    out  32        load data, extended per d_memop; 0 for stores
//  d_err      out  1         one-cycle pulse, one cycle after a misaligned request; no RAM access made
//  mem_en     out  1         RAM access strobe
//  mem_we     out  1         RAM write
//  mem_be     out  4         RAM byte enables
//  mem_addr   out  ADDR_W-2  RAM word address
//  mem_wdata  out  32        RAM write data, lane-shifted
//  mem_rdata  in   32        RAM read data, valid the cycle after mem_en
// BEHAVIOUR
//  Reset: all registered state clears immediately. State = IDLE, run counter = 0.
//    All outputs are 0 while rst is high.
//    Any in-flight response is discarded, so no rvalid or err appears after reset.
//  Arbitration, evaluated every cycle; the RAM port is free every cycle:
//    Misaligned data requests (lh/lhu/sh with addr[0]=1; lw/sw with addr[1:0]!=0) never
//    take the port. They set pending-error; d_gnt stays 0; d_err pulses next cycle;
//    fetch may be granted in the same cycle.
//    Aligned data request and run counter < MAX_DATA_RUN: data wins.
//    Aligned data request and run counter = MAX_DATA_RUN while if_req is high: fetch wins.
//    Run counter: increments on each data grant while if_req is high, saturating at MAX_DATA_RUN.
//    It clears on any fetch grant, and on any cycle where if_req is low.
//  Grant cycle:
//    mem_en = 1.
//    mem_addr = addr[ADDR_W-1:2].
//    mem_we = d_we for a data grant, 0 for a fetch grant.
//  State machine (who owns next cycle's response); transitions each clk:
//    IDLE -> F_RESP if fetch granted; -> D_RESP if data granted; -> D_ERR if misaligned; else IDLE.
//    Each of F_RESP / D_RESP / D_ERR asserts its response for exactly 1 cycle.
//    Each re-arbitrates in that same cycle (back-to-back grants, full throughput).
//  Responses:
//    F_RESP: if_rvalid=1, if_rdata=mem_rdata.
//    D_RESP: d_rvalid=1. d_rdata = aligned load, or 0 for a store.
//    D_ERR: d_err=1.
//  Lanes (lo = addr[1:0], registered with the grant for the response):
//    Byte: be = 0001 << lo; wdata = {4{d_wdata[7:0]}}.
//    Half: be = 0011 << lo; wdata = {2{d_wdata[15:0]}}.
//    Word: be = 1111; wdata = d_wdata.
//    Load: select the byte/half at lo from mem_rdata; sign-extend for lb/lh, zero-extend for lbu/lhu.
//  Simultaneous fetch and data requests with run counter < MAX: data first, fetch next cycle.
//    Worst-case fetch wait is MAX_DATA_RUN cycles.
//  A requester must not drop req before gnt; if it does, no access is made and no state changes.
// STRUCTURE
//  mem_arb_pkg:
//    MemOp localparams (MEMOP_LB..MEMOP_LHU).
//    typedef enum {IDLE, F_RESP, D_RESP, D_ERR} arb_state_t.
//    Misalign check function.
//  Sub-module mem_lane_align: combinational.
//    Store path: memop, lo, wdata -> be, shifted wdata.
//    Load path: memop, lo, rdata -> extended load.
//    Instantiated once.
//  Top holds the arbiter, run counter, FSM, and response registers (owner, memop, lo).
// TESTING
//  1. Fetch only: if_req, if_addr=0x10 every cycle -> if_gnt each cycle, mem_addr=0x4; if_rvalid every cycle from the 2nd on.
//  2. Collision: if_req + d_req lw 0x20 (MAX_DATA_RUN=4) -> d_gnt first, if_gnt next cycle; d_rvalid precedes if_rvalid.
//  3. Starvation: if_req + d_req held high 10 cycles -> grant pattern DDDDF DDDDF.
//  4. Lanes:
//     sb 0xAB @0x103 -> mem_be=1000, mem_wdata=0xABABABAB.
//     lb @0x103 with mem_rdata=0x80000000 -> d_rdata=0xFFFFFF80.
//     lhu @0x102 -> 0x00008000.
//  5. Misalign: lw @0x102 -> no mem_en, d_gnt=0, d_err=1 one cycle later; a concurrent fetch is granted in that cycle.
//  6. Reset mid-op: assert rst the cycle after d_gnt -> d_rvalid is never asserted, all outputs 0;
//     after release, the first request is served normally.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the unified instruction/data memory arbiter.
// MemOp encodings, response-owner states and the lane-size decode.
package mem_arb_pkg;

    localparam logic [2:0] MEMOP_LB  = 3'b000;
    localparam logic [2:0] MEMOP_LH  = 3'b001;
    localparam logic [2:0] MEMOP_LW  = 3'b010;
    localparam logic [2:0] MEMOP_LBU = 3'b100;
    localparam logic [2:0] MEMOP_LHU = 3'b101;

    typedef enum logic [1:0] {
        IDLE,
        F_RESP,
        D_RESP,
        D_ERR
    } arb_state_t;

    typedef enum logic [1:0] {
        SIZE_B,
        SIZE_H,
        SIZE_W
    } mem_size_t;

    // Unlisted MemOp codes fall through to a full word access.
    function automatic mem_size_t memop_size(input logic [2:0] memop);
        case (memop)
            MEMOP_LB, MEMOP_LBU: return SIZE_B;
            MEMOP_LH, MEMOP_LHU: return SIZE_H;
            MEMOP_LW:            return SIZE_W;
            default:             return SIZE_W;
        endcase
    endfunction

    function automatic logic memop_signed(input logic [2:0] memop);
        return (memop == MEMOP_LB) || (memop == MEMOP_LH);
    endfunction

    function automatic logic is_misaligned(input logic [2:0] memop, input logic [1:0] lo);
        case (memop_size(memop))
            SIZE_B:  return 1'b0;
            SIZE_H:  return lo[0];
            default: return lo != 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane steering: store data/byte enables out to the RAM,
// and load data selection plus sign/zero extension on the way back.
module mem_lane_align
    import mem_arb_pkg::*;
(
    input  logic [2:0]  st_memop,
    input  logic [1:0]  st_lo,
    input  logic [31:0] st_wdata,
    output logic [3:0]  st_be,
    output logic [31:0] st_data,
    input  logic [2:0]  ld_memop,
    input  logic [1:0]  ld_lo,
    input  logic [31:0] ld_rdata,
    output logic [31:0] ld_data
);

    logic [31:0] ld_shifted;
    logic        ld_sign;

    // Narrow stores are replicated across all lanes; byte enables pick the live one.
    always_comb begin
        st_be   = 4'b1111;
        st_data = st_wdata;
        case (memop_size(st_memop))
            SIZE_B: begin
                st_be   = 4'b0001 << st_lo;
                st_data = {4{st_wdata[7:0]}};
            end
            SIZE_H: begin
                st_be   = 4'b0011 << st_lo;
                st_data = {2{st_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        ld_shifted = ld_rdata >> {ld_lo, 3'b000};
        ld_sign    = memop_signed(ld_memop);
        ld_data    = ld_rdata;
        case (memop_size(ld_memop))
            SIZE_B:  ld_data = {{24{ld_sign & ld_shifted[7]}}, ld_shifted[7:0]};
            SIZE_H:  ld_data = {{16{ld_sign & ld_shifted[15]}}, ld_shifted[15:0]};
            default: ;
        endcase
    end

endmodule

// File: rtl/unified_mem_arbiter.sv
// Shares one single-port synchronous RAM between instruction fetch and data access,
// one grant per cycle, with a bounded data run so fetch is never starved.
module unified_mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int MAX_DATA_RUN = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [31:0]       if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [2:0]        d_memop,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [31:0]       d_rdata,
    output logic              d_err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [ADDR_W-3:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    localparam int              RUN_W   = $clog2(MAX_DATA_RUN + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_DATA_RUN);

    arb_state_t       state_q, state_d;
    logic [RUN_W-1:0] run_q, run_d;
    logic [2:0]       memop_q, memop_d;
    logic [1:0]       lo_q, lo_d;
    logic             we_q, we_d;
    logic             err_q, err_d;

    logic        d_mis;
    logic        d_take;
    logic        f_take;
    logic        d_flag;
    logic [3:0]  st_be;
    logic [31:0] st_data;
    logic [31:0] ld_data;
    logic        unused_addr_bits;

    assign unused_addr_bits = ^if_addr[1:0];

    // While an error is pending the requester is still holding the same bad
    // request, so it must not be flagged a second time.
    always_comb begin
        d_mis  = is_misaligned(d_memop, d_addr[1:0]);
        d_take = !rst && d_req && !d_mis && !((run_q == RUN_MAX) && if_req);
        f_take = !rst && if_req && !d_take;
        d_flag = !rst && d_req && d_mis && !err_q;
    end

    assign if_gnt = f_take;
    assign d_gnt  = d_take;

    always_comb begin
        mem_en    = d_take | f_take;
        mem_we    = d_take & d_we;
        mem_be    = 4'b0000;
        mem_addr  = '0;
        mem_wdata = '0;
        if (d_take) begin
            mem_be    = st_be;
            mem_addr  = d_addr[ADDR_W-1:2];
            mem_wdata = st_data;
        end else if (f_take) begin
            mem_be   = 4'b1111;
            mem_addr = if_addr[ADDR_W-1:2];
        end
    end

    // Fetch outranks the error owner so both responses can land in the same cycle.
    always_comb begin
        state_d = IDLE;
        run_d   = run_q;
        memop_d = memop_q;
        lo_d    = lo_q;
        we_d    = we_q;
        err_d   = d_flag;
        if (f_take) begin
            state_d = F_RESP;
        end else if (d_take) begin
            state_d = D_RESP;
        end else if (d_flag) begin
            state_d = D_ERR;
        end
        if (d_take) begin
            memop_d = d_memop;
            lo_d    = d_addr[1:0];
            we_d    = d_we;
        end
        if (!if_req || f_take) begin
            run_d = '0;
        end else if (d_take && (run_q != RUN_MAX)) begin
            run_d = run_q + RUN_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            run_q   <= '0;
            memop_q <= MEMOP_LW;
            lo_q    <= 2'b00;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            run_q   <= run_d;
            memop_q <= memop_d;
            lo_q    <= lo_d;
            we_q    <= we_d;
            err_q   <= err_d;
        end
    end

    mem_lane_align u_lane (
        .st_memop (d_memop),
        .st_lo    (d_addr[1:0]),
        .st_wdata (d_wdata),
        .st_be    (st_be),
        .st_data  (st_data),
        .ld_memop (memop_q),
        .ld_lo    (lo_q),
        .ld_rdata (mem_rdata),
        .ld_data  (ld_data)
    );

    assign if_rvalid = (state_q == F_RESP);
    assign if_rdata  = (state_q == F_RESP) ? mem_rdata : 32'h0;
    assign d_rvalid  = (state_q == D_RESP);
    assign d_rdata   = ((state_q == D_RESP) && !we_q) ? ld_data : 32'h0;
    assign d_err     = err_q;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Scoreboard bench for unified_mem_arbiter: a reference arbitration model predicts
// grants each cycle and queues the expected responses for the following cycle.
module tb_unified_mem_arbiter;

    localparam logic [2:0] OP_LB  = 3'b000;
    localparam logic [2:0] OP_LH  = 3'b001;
    localparam logic [2:0] OP_LW  = 3'b010;
    localparam logic [2:0] OP_LBU = 3'b100;
    localparam logic [2:0] OP_LHU = 3'b101;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt, if_rvalid;
    logic [31:0] if_rdata;
    logic        d_req, d_we;
    logic [2:0]  d_memop;
    logic [31:0] d_addr, d_wdata;
    logic        d_gnt, d_rvalid, d_err;
    logic [31:0] d_rdata;
    logic        mem_en, mem_we;
    logic [3:0]  mem_be;
    logic [29:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = 32'h0;

    int          checks = 0;
    int          errors = 0;
    int          runCnt;
    logic        expFVal, expDVal, expErr;
    logic        predF, predD, predErr;
    logic [31:0] fQ[$];
    logic [31:0] dQ[$];

    always #5 clk = ~clk;

    unified_mem_arbiter #(.ADDR_W(32), .MAX_DATA_RUN(4)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_memop(d_memop), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_gnt(d_gnt), .d_rvalid(d_rvalid),
        .d_rdata(d_rdata), .d_err(d_err),
        .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    function automatic logic [31:0] ramWord(input logic [29:0] w);
        if (w == 30'h40) return 32'h8000_0000;
        return {w[15:0], ~w[15:0]} ^ 32'h1357_2468;
    endfunction

    always @(posedge clk) if (mem_en) mem_rdata <= ramWord(mem_addr);

    function automatic logic modelMis(input logic [2:0] op, input logic [1:0] lo);
        case (op)
            3'b000, 3'b100: return 1'b0;
            3'b001, 3'b101: return lo[0];
            default:        return lo != 2'b00;
        endcase
    endfunction

    function automatic logic [3:0] modelBe(input logic [2:0] op, input logic [1:0] lo);
        case (op)
            3'b000, 3'b100: case (lo)
                                2'd0: return 4'b0001;
                                2'd1: return 4'b0010;
                                2'd2: return 4'b0100;
                                default: return 4'b1000;
                            endcase
            3'b001, 3'b101: return lo[1] ? 4'b1100 : 4'b0011;
            default:        return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] modelWdata(input logic [2:0] op, input logic [31:0] d);
        case (op)
            3'b000, 3'b100: return {d[7:0], d[7:0], d[7:0], d[7:0]};
            3'b001, 3'b101: return {d[15:0], d[15:0]};
            default:        return d;
        endcase
    endfunction

    function automatic logic [31:0] modelLoad(input logic [2:0] op, input logic [1:0] lo,
                                              input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        case (lo)
            2'd0: b = w[7:0];
            2'd1: b = w[15:8];
            2'd2: b = w[23:16];
            default: b = w[31:24];
        endcase
        h = lo[1] ? w[31:16] : w[15:0];
        case (op)
            3'b000:  return {{24{b[7]}}, b};
            3'b100:  return {24'h0, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b101:  return {16'h0, h};
            default: return w;
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One cycle: drive at the falling edge, check responses owed from the last
    // cycle, predict this cycle's grants and queue what they must return.
    task automatic applyStimulus(input logic fr, input logic [31:0] fa, input logic dr,
                                 input logic dw, input logic [2:0] dm,
                                 input logic [31:0] da, input logic [31:0] dwd);
        logic mis;
        @(negedge clk);
        if_req = fr; if_addr = fa;
        d_req = dr; d_we = dw; d_memop = dm; d_addr = da; d_wdata = dwd;
        #1;
        checkOutput("if_rvalid", if_rvalid, expFVal);
        checkOutput("d_rvalid", d_rvalid, expDVal);
        checkOutput("d_err", d_err, expErr);
        if (expFVal && fQ.size() > 0) checkOutput("if_rdata", if_rdata, fQ.pop_front());
        if (expDVal && dQ.size() > 0) checkOutput("d_rdata", d_rdata, dQ.pop_front());

        mis     = modelMis(dm, da[1:0]);
        predD   = !rst && dr && !mis && !((runCnt == 4) && fr);
        predF   = !rst && fr && !predD;
        predErr = !rst && dr && mis && !expErr;

        checkOutput("if_gnt", if_gnt, predF);
        checkOutput("d_gnt", d_gnt, predD);
        checkOutput("mem_en", mem_en, predF | predD);
        if (predF || predD) begin
            checkOutput("mem_addr", mem_addr, predD ? da[31:2] : fa[31:2]);
            checkOutput("mem_we", mem_we, predD & dw);
        end
        if (predD && dw) begin
            checkOutput("mem_be", mem_be, modelBe(dm, da[1:0]));
            checkOutput("mem_wdata", mem_wdata, modelWdata(dm, dwd));
        end
        if (rst) begin
            checkOutput("rst_if_rdata", if_rdata, 32'h0);
            checkOutput("rst_d_rdata", d_rdata, 32'h0);
            checkOutput("rst_mem_we", mem_we, 32'h0);
            checkOutput("rst_mem_be", mem_be, 32'h0);
            checkOutput("rst_mem_addr", mem_addr, 32'h0);
            checkOutput("rst_mem_wdata", mem_wdata, 32'h0);
        end

        if (predF) fQ.push_back(ramWord(fa[31:2]));
        if (predD) dQ.push_back(dw ? 32'h0 : modelLoad(dm, da[1:0], ramWord(da[31:2])));
        expFVal = predF;
        expDVal = predD;
        expErr  = predErr;
        if (rst || !fr || predF) runCnt = 0;
        else if (predD && runCnt < 4) runCnt++;
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, OP_LW, 32'h0, 32'h0);
    endtask

    initial begin
        logic        fr, dr, dw, errHold;
        logic [2:0]  dm;
        logic [31:0] fa, da, dwd;
        logic [9:0]  obsPat, expPat;

        rst = 1'b1;
        if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_memop = OP_LW; d_addr = 0; d_wdata = 0;
        runCnt = 0; expFVal = 0; expDVal = 0; expErr = 0;

        // Reset: requests present but nothing may be granted.
        applyStimulus(1'b1, 32'h10, 1'b1, 1'b0, OP_LW, 32'h20, 32'h0);
        applyStimulus(1'b1, 32'h10, 1'b1, 1'b1, OP_LW, 32'h24, 32'h55);
        idleCycle();
        rst = 1'b0;

        $display("[TB] fetch only");
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 32'h10, 1'b0, 1'b0, OP_LW, 32'h0, 32'h0);
            checkOutput("fetch_mem_addr", mem_addr, 32'h4);
        end
        idleCycle();

        $display("[TB] collision");
        applyStimulus(1'b1, 32'h10, 1'b1, 1'b0, OP_LW, 32'h20, 32'h0);
        checkOutput("coll_d_first", d_gnt, 32'h1);
        applyStimulus(1'b1, 32'h10, 1'b0, 1'b0, OP_LW, 32'h0, 32'h0);
        checkOutput("coll_f_next", if_gnt, 32'h1);
        idleCycle();

        $display("[TB] starvation");
        idleCycle();
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, 32'h40, 1'b1, 1'b0, OP_LW, 32'h100 + 32'(i * 4), 32'h0);
            obsPat[i] = d_gnt;
            expPat[i] = (i % 5) != 4;
        end
        checkOutput("starve_pattern", 32'(obsPat), 32'(expPat));
        idleCycle();

        $display("[TB] lanes");
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, OP_LB, 32'h103, 32'h0000_00AB);
        checkOutput("sb_be", mem_be, 32'h8);
        checkOutput("sb_wdata", mem_wdata, 32'hABAB_ABAB);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, OP_LB, 32'h103, 32'h0);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, OP_LHU, 32'h102, 32'h0);
        checkOutput("lb_sext", d_rdata, 32'hFFFF_FF80);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, OP_LH, 32'h102, 32'h0);
        checkOutput("lhu_zext", d_rdata, 32'h0000_8000);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, OP_LH, 32'h102, 32'h0000_1234);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, OP_LBU, 32'h101, 32'h0);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 3'b111, 32'h44, 32'hDEAD_BEEF);
        idleCycle();

        $display("[TB] misalign");
        applyStimulus(1'b1, 32'h200, 1'b1, 1'b0, OP_LW, 32'h102, 32'h0);
        checkOutput("mis_fetch_gnt", if_gnt, 32'h1);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, OP_LW, 32'h102, 32'h0);
        checkOutput("mis_err_pulse", d_err, 32'h1);
        idleCycle();
        idleCycle();

        $display("[TB] reset mid-op");
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, OP_LW, 32'h100, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        expFVal = 0; expDVal = 0; expErr = 0; runCnt = 0;
        fQ.delete();
        dQ.delete();
        applyStimulus(1'b1, 32'h10, 1'b1, 1'b0, OP_LW, 32'h100, 32'h0);
        idleCycle();
        rst = 1'b0;
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, OP_LW, 32'h100, 32'h0);
        idleCycle();
        checkOutput("post_rst_load", d_rdata, 32'h8000_0000);

        $display("[TB] random traffic");
        fr = 0; dr = 0; dw = 0; dm = OP_LW; fa = 0; da = 0; dwd = 0; errHold = 0;
        for (int c = 0; c < 200; c++) begin
            if (!fr && $urandom_range(0, 3) != 0) begin
                fr = 1'b1;
                fa = $urandom_range(0, 4095);
            end
            if (!dr && $urandom_range(0, 2) != 0) begin
                dr  = 1'b1;
                dw  = 1'($urandom_range(0, 1));
                dm  = 3'($urandom_range(0, 7));
                da  = $urandom_range(0, 1023);
                dwd = $urandom();
            end
            applyStimulus(fr, fa, dr, dw, dm, da, dwd);
            if (predF) fr = 1'b0;
            if (predD) begin
                dr = 1'b0;
            end else if (predErr) begin
                errHold = 1'b1;
            end else if (errHold) begin
                dr = 1'b0;
                errHold = 1'b0;
            end
        end
        idleCycle();
        idleCycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
